// File: rtl/esc_ctrl_pkg.sv
// ============================================================================
// Module   : esc_ctrl_pkg
// Brief    : Shared types and constants for the quad-rotor ESC spin controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package esc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_SPINUP   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_e;

  localparam int FRNT = 0;
  localparam int BCK  = 1;
  localparam int LFT  = 2;
  localparam int RGHT = 3;

  localparam logic [10:0] SPD_MAX = 11'd2047;
  localparam int          MIX_W   = 13;

endpackage

`default_nettype wire

// File: rtl/esc_mix_sat.sv
// ============================================================================
// Module   : esc_mix_sat
// Brief    : One motor's signed thrust/correction mix, saturated to [IDLE_SPD, SPD_MAX].
// Revision : 1.0
// ============================================================================
`default_nettype none

module esc_mix_sat
  import esc_ctrl_pkg::*;
#(
  parameter logic [10:0] IDLE_SPD = 11'd200
) (
  input  logic [10:0] thrust_i,
  input  logic [9:0]  corr_a_i,
  input  logic [9:0]  corr_b_i,
  input  logic        neg_a_i,
  input  logic        neg_b_i,
  output logic [10:0] spd_o
);

  logic signed [MIX_W-1:0] w_thr;
  logic signed [MIX_W-1:0] w_idle;
  logic signed [MIX_W-1:0] w_max;
  logic signed [MIX_W-1:0] w_a;
  logic signed [MIX_W-1:0] w_b;
  logic signed [MIX_W-1:0] w_sum;

  assign w_thr  = signed'({2'b00, thrust_i});
  assign w_idle = signed'({2'b00, IDLE_SPD});
  assign w_max  = signed'({2'b00, SPD_MAX});
  assign w_a    = signed'({{3{corr_a_i[9]}}, corr_a_i});
  assign w_b    = signed'({{3{corr_b_i[9]}}, corr_b_i});
  assign w_sum  = w_thr + w_idle + (neg_a_i ? -w_a : w_a) + (neg_b_i ? -w_b : w_b);

  always_comb begin
    spd_o = w_sum[10:0];
    if (w_sum < w_idle) begin
      spd_o = IDLE_SPD;
    end else if (w_sum > w_max) begin
      spd_o = SPD_MAX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/esc_spin_ctrl.sv
// ============================================================================
// Module   : esc_spin_ctrl
// Brief    : Arms, ramps and mixes four ESC speeds/trims, committing on frame ticks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module esc_spin_ctrl
  import esc_ctrl_pkg::*;
#(
  parameter logic [10:0] IDLE_SPD    = 11'd200,
  parameter logic [10:0] SPINUP_STEP = 11'd16,
  parameter logic [10:0] ARM_THR_MAX = 11'd64,
  parameter int          WDOG_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frm_tick_i,
  input  logic        arm_i,
  input  logic        kill_i,
  input  logic        vld_i,
  input  logic [10:0] thrust_i,
  input  logic [9:0]  ptch_i,
  input  logic [9:0]  roll_i,
  input  logic [9:0]  yaw_i,
  input  logic        off_wr_i,
  input  logic [1:0]  off_sel_i,
  input  logic [9:0]  off_data_i,
  output logic [10:0] frnt_spd_o,
  output logic [10:0] bck_spd_o,
  output logic [10:0] lft_spd_o,
  output logic [10:0] rght_spd_o,
  output logic [9:0]  frnt_off_o,
  output logic [9:0]  bck_off_o,
  output logic [9:0]  lft_off_o,
  output logic [9:0]  rght_off_o,
  output logic [1:0]  state_o,
  output logic        armed_o
);

  localparam int WD_W = $clog2(WDOG_FRAMES + 1);

  state_e          state_q, state_d;
  logic [10:0]     spd_q  [4];
  logic [10:0]     spd_d  [4];
  logic [10:0]     stg_q  [4];
  logic [10:0]     stg_d  [4];
  logic [9:0]      trim_q [4];
  logic [9:0]      trim_d [4];
  logic [9:0]      off_q  [4];
  logic [9:0]      off_d  [4];
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic [10:0] w_mix    [4];
  logic [11:0] w_up_sum [4];
  logic [10:0] w_up_spd [4];
  logic [10:0] w_dn_spd [4];
  logic [3:0]  w_up_idle;
  logic [3:0]  w_dn_zero;

  // Motor order frnt/bck/lft/rght: pitch drives the front pair, roll the side pair;
  // yaw opposes on front/back and adds on left/right.
  for (genvar gi = 0; gi < 4; gi++) begin : g_motor
    localparam logic c_use_roll = (gi >= 2);
    localparam logic c_neg_a    = ((gi % 2) == 1);
    localparam logic c_neg_b    = (gi < 2);

    esc_mix_sat #(
      .IDLE_SPD (IDLE_SPD)
    ) u_mix (
      .thrust_i (thrust_i),
      .corr_a_i (c_use_roll ? roll_i : ptch_i),
      .corr_b_i (yaw_i),
      .neg_a_i  (c_neg_a),
      .neg_b_i  (c_neg_b),
      .spd_o    (w_mix[gi])
    );

    assign w_up_sum[gi]  = {1'b0, spd_q[gi]} + {1'b0, SPINUP_STEP};
    assign w_up_spd[gi]  = (w_up_sum[gi] >= {1'b0, IDLE_SPD}) ? IDLE_SPD : w_up_sum[gi][10:0];
    assign w_dn_spd[gi]  = (spd_q[gi] > SPINUP_STEP) ? (spd_q[gi] - SPINUP_STEP) : 11'd0;
    assign w_up_idle[gi] = (w_up_spd[gi] == IDLE_SPD);
    assign w_dn_zero[gi] = (w_dn_spd[gi] == 11'd0);
  end

  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    stg_d   = stg_q;
    trim_d  = trim_q;
    off_d   = off_q;
    wdog_d  = wdog_q;

    if (off_wr_i) begin
      trim_d[off_sel_i] = off_data_i;
    end
    if (frm_tick_i) begin
      off_d = trim_q;
    end

    case (state_q)
      ST_DISARMED: begin
        for (int i = 0; i < 4; i++) spd_d[i] = 11'd0;
        if (arm_i && (thrust_i < ARM_THR_MAX)) begin
          state_d = ST_SPINUP;
        end
      end
      ST_SPINUP: begin
        if (!arm_i) begin
          state_d = ST_DISARMED;
          for (int i = 0; i < 4; i++) spd_d[i] = 11'd0;
        end else if (frm_tick_i) begin
          spd_d = w_up_spd;
          if (&w_up_idle) begin
            state_d = ST_ARMED;
            wdog_d  = '0;
            for (int i = 0; i < 4; i++) stg_d[i] = IDLE_SPD;
          end
        end
      end
      ST_ARMED: begin
        if (vld_i) begin
          stg_d = w_mix;
        end
        // Commit uses the pre-edge staging, so a coincident vld lands one frame later.
        if (frm_tick_i) begin
          spd_d = stg_q;
        end
        if (!arm_i) begin
          state_d = ST_FAILSAFE;
        end else if (vld_i) begin
          wdog_d = '0;
        end else if (frm_tick_i) begin
          wdog_d = wdog_q + WD_W'(1);
          if (wdog_q == WD_W'(WDOG_FRAMES - 1)) begin
            state_d = ST_FAILSAFE;
          end
        end
      end
      ST_FAILSAFE: begin
        if (frm_tick_i) begin
          spd_d = w_dn_spd;
          if (&w_dn_zero) begin
            state_d = ST_DISARMED;
          end
        end
      end
      default: state_d = ST_DISARMED;
    endcase

    if (kill_i) begin
      state_d = ST_DISARMED;
      for (int i = 0; i < 4; i++) spd_d[i] = 11'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DISARMED;
      wdog_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        spd_q[i]  <= '0;
        stg_q[i]  <= '0;
        trim_q[i] <= '0;
        off_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      spd_q   <= spd_d;
      stg_q   <= stg_d;
      trim_q  <= trim_d;
      off_q   <= off_d;
    end
  end

  assign frnt_spd_o = spd_q[FRNT];
  assign bck_spd_o  = spd_q[BCK];
  assign lft_spd_o  = spd_q[LFT];
  assign rght_spd_o = spd_q[RGHT];
  assign frnt_off_o = off_q[FRNT];
  assign bck_off_o  = off_q[BCK];
  assign lft_off_o  = off_q[LFT];
  assign rght_off_o = off_q[RGHT];
  assign state_o    = state_q;
  assign armed_o    = (state_q == ST_ARMED);

endmodule

`default_nettype wire

// File: tb/tb_esc_spin_ctrl.sv
// ============================================================================
// Module   : tb_esc_spin_ctrl
// Brief    : Scenario bench for esc_spin_ctrl with an expected-result queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_esc_spin_ctrl;
  import esc_ctrl_pkg::*;

  typedef logic [3:0][10:0] spd4_t;
  typedef logic [3:0][9:0]  off4_t;
  typedef struct packed {
    logic [1:0] st;
    spd4_t      spd;
    off4_t      off;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n, frm_tick, arm, kill, vld, off_wr;
  logic [10:0] thrust;
  logic [9:0]  ptch, roll, yaw, off_data;
  logic [1:0]  off_sel;
  wire  [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  wire  [9:0]  frnt_off, bck_off, lft_off, rght_off;
  wire  [1:0]  state;
  wire         armed;

  obs_t  obs;
  obs_t  e;
  obs_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  spd4_t stg_m;
  off4_t trim_m, off_m;

  esc_spin_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frm_tick_i (frm_tick),
    .arm_i      (arm),
    .kill_i     (kill),
    .vld_i      (vld),
    .thrust_i   (thrust),
    .ptch_i     (ptch),
    .roll_i     (roll),
    .yaw_i      (yaw),
    .off_wr_i   (off_wr),
    .off_sel_i  (off_sel),
    .off_data_i (off_data),
    .frnt_spd_o (frnt_spd),
    .bck_spd_o  (bck_spd),
    .lft_spd_o  (lft_spd),
    .rght_spd_o (rght_spd),
    .frnt_off_o (frnt_off),
    .bck_off_o  (bck_off),
    .lft_off_o  (lft_off),
    .rght_off_o (rght_off),
    .state_o    (state),
    .armed_o    (armed)
  );

  assign obs = {state, rght_spd, lft_spd, bck_spd, frnt_spd, rght_off, lft_off, bck_off, frnt_off};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  function automatic logic [10:0] sat(int v);
    if (v < 200)  return 11'd200;
    if (v > 2047) return 11'd2047;
    return 11'(v);
  endfunction

  function automatic spd4_t mixq(int t, int p, int r, int y);
    spd4_t q;
    q[0] = sat(t + 200 + p - y);
    q[1] = sat(t + 200 - p - y);
    q[2] = sat(t + 200 + r + y);
    q[3] = sat(t + 200 - r + y);
    return q;
  endfunction

  function automatic spd4_t fill(int v);
    spd4_t q;
    for (int i = 0; i < 4; i++) q[i] = 11'(v);
    return q;
  endfunction

  function automatic obs_t mk(state_e st, spd4_t s, off4_t o);
    obs_t v;
    v.st  = st;
    v.spd = s;
    v.off = o;
    return v;
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("st=%0d spd=%0d/%0d/%0d/%0d off=%0d/%0d/%0d/%0d", v.st,
                     v.spd[0], v.spd[1], v.spd[2], v.spd[3],
                     v.off[0], v.off[1], v.off[2], v.off[3]);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  // A tick commits the trims held before the edge.
  task automatic tick();
    off_m = trim_m;
    frm_tick = 1'b1;
    cyc();
    frm_tick = 1'b0;
  endtask

  task automatic set_cmd(int t, int p, int r, int y);
    thrust = 11'(t);
    ptch   = 10'(p);
    roll   = 10'(r);
    yaw    = 10'(y);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frm_tick = 1'b0; arm = 1'b0; kill = 1'b0; vld = 1'b0; off_wr = 1'b0;
    off_sel = 2'd0; off_data = 10'd0;
    set_cmd(0, 0, 0, 0);
    trim_m = '0; off_m = '0; stg_m = '0;
    repeat (3) cyc();
    sb.push_back(mk(ST_DISARMED, fill(0), off4_t'(0)));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset: got %s required %s", fmt(obs), fmt(e)); end
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %0d required 0", armed); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_arm_refused();
    arm = 1'b1;
    thrust = 11'd100;
    cyc();
    for (int k = 0; k < 5; k++) begin
      sb.push_back(mk(ST_DISARMED, fill(0), trim_m));
      tick();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL arm_refused_%0d: got %s required %s", k, fmt(obs), fmt(e)); end
      cyc();
    end
    arm = 1'b0;
    cyc();
  endtask

  task automatic test_spinup();
    set_cmd(0, 0, 0, 0);
    arm = 1'b1;
    cyc();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL spinup_entry: got st=%0d required 1", state); end
    for (int k = 1; k <= 13; k++) begin
      sb.push_back(mk((k == 13) ? ST_ARMED : ST_SPINUP, fill((16 * k > 200) ? 200 : 16 * k), trim_m));
      tick();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL spinup_tick%0d: got %s required %s", k, fmt(obs), fmt(e)); end
      cyc(); cyc();
    end
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL spinup_armed: got %0d required 1", armed); end
    stg_m = fill(200);
  endtask

  task automatic test_mix_commit();
    set_cmd(500, 40, -20, 10);
    vld = 1'b1;
    cyc();
    vld = 1'b0;
    cyc();
    sb.push_back(mk(ST_ARMED, stg_m, off_m));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mix_hold: got %s required %s", fmt(obs), fmt(e)); end
    stg_m = mixq(500, 40, -20, 10);
    sb.push_back(mk(ST_ARMED, stg_m, trim_m));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mix_commit: got %s required %s", fmt(obs), fmt(e)); end
    cyc();
  endtask

  task automatic test_saturation();
    // vld coincident with the tick: the tick must commit the older staging
    set_cmd(2000, 100, 0, -100);
    sb.push_back(mk(ST_ARMED, stg_m, trim_m));
    vld = 1'b1;
    tick();
    vld = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL sat_coincident: got %s required %s", fmt(obs), fmt(e)); end
    stg_m = mixq(2000, 100, 0, -100);
    sb.push_back(mk(ST_ARMED, stg_m, trim_m));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL sat_high: got %s required %s", fmt(obs), fmt(e)); end
    set_cmd(0, -300, 0, 0);
    vld = 1'b1;
    cyc();
    vld = 1'b0;
    stg_m = mixq(0, -300, 0, 0);
    sb.push_back(mk(ST_ARMED, stg_m, trim_m));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL sat_low: got %s required %s", fmt(obs), fmt(e)); end
    cyc();
  endtask

  task automatic test_watchdog_failsafe();
    int    wd;
    bit    done;
    spd4_t cur;
    set_cmd(500, 40, -20, 10);
    vld = 1'b1;
    cyc();
    vld = 1'b0;
    stg_m = mixq(500, 40, -20, 10);
    wd = 0;
    for (int k = 1; k <= 4; k++) begin
      wd++;
      sb.push_back(mk((wd == 4) ? ST_FAILSAFE : ST_ARMED, stg_m, trim_m));
      tick();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL wdog_tick%0d: got %s required %s", k, fmt(obs), fmt(e)); end
      cyc();
    end
    cur = stg_m;
    done = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        cur[i] = (cur[i] > 11'd16) ? cur[i] - 11'd16 : 11'd0;
        if (cur[i] != 11'd0) done = 1'b0;
      end
      sb.push_back(mk(done ? ST_DISARMED : ST_FAILSAFE, cur, trim_m));
      if (k == 1) begin
        set_cmd(1000, 0, 0, 0);
        vld = 1'b1;
      end
      tick();
      vld = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL failsafe_tick%0d: got %s required %s", k, fmt(obs), fmt(e)); end
      cyc();
    end
    checks++;
    if (!done) begin errors++; $display("FAIL failsafe_bound: got not_disarmed required disarmed"); end
    cyc();
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL failsafe_stay: got st=%0d required 0", state); end
    arm = 1'b0;
    cyc();
  endtask

  task automatic test_trim_kill();
    off_sel = 2'd2; off_data = 10'd37; off_wr = 1'b1;
    cyc();
    off_wr = 1'b0;
    trim_m[2] = 10'd37;
    cyc();
    sb.push_back(mk(ST_DISARMED, fill(0), off_m));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL trim_before_tick: got %s required %s", fmt(obs), fmt(e)); end
    // arm drop during spin-up
    set_cmd(0, 0, 0, 0);
    arm = 1'b1;
    cyc();
    for (int k = 1; k <= 3; k++) begin
      sb.push_back(mk(ST_SPINUP, fill(16 * k), trim_m));
      tick();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL trim_spin_tick%0d: got %s required %s", k, fmt(obs), fmt(e)); end
    end
    arm = 1'b0;
    sb.push_back(mk(ST_DISARMED, fill(0), off_m));
    cyc();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL spinup_arm_drop: got %s required %s", fmt(obs), fmt(e)); end
    arm = 1'b1;
    cyc();
    for (int k = 1; k <= 13; k++) begin
      sb.push_back(mk((k == 13) ? ST_ARMED : ST_SPINUP, fill((16 * k > 200) ? 200 : 16 * k), trim_m));
      tick();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rearm_tick%0d: got %s required %s", k, fmt(obs), fmt(e)); end
    end
    sb.push_back(mk(ST_ARMED, fill(200), trim_m));
    off_sel = 2'd0; off_data = 10'd5; off_wr = 1'b1;
    tick();
    off_wr = 1'b0;
    trim_m[0] = 10'd5;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL trim_coincident: got %s required %s", fmt(obs), fmt(e)); end
    sb.push_back(mk(ST_ARMED, fill(200), trim_m));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL trim_next_tick: got %s required %s", fmt(obs), fmt(e)); end
    set_cmd(500, 40, -20, 10);
    vld = 1'b1;
    cyc();
    vld = 1'b0;
    sb.push_back(mk(ST_ARMED, mixq(500, 40, -20, 10), trim_m));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL kill_pre: got %s required %s", fmt(obs), fmt(e)); end
    cyc();
    sb.push_back(mk(ST_DISARMED, fill(0), off_m));
    kill = 1'b1;
    cyc();
    kill = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL kill: got %s required %s", fmt(obs), fmt(e)); end
    sb.push_back(mk(ST_DISARMED, fill(0), trim_m));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL post_kill_tick: got %s required %s", fmt(obs), fmt(e)); end
    arm = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_arm_refused();
    test_spinup();
    test_mix_commit();
    test_saturation();
    test_watchdog_failsafe();
    test_trim_kill();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
